// File: rtl/dcache_tracker_pkg.sv
// Shared types for the dcache port tracker: error indices, flush FSM states
// and the latency histogram bin count.
package dcache_tracker_pkg;

  typedef enum logic [2:0] {
    ERR_RVALID     = 3'd0,
    ERR_OVF        = 3'd1,
    ERR_SPUR_GNT   = 3'd2,
    ERR_REQ_DROP   = 3'd3,
    ERR_MULTI_GNT  = 3'd4,
    ERR_TIMEOUT    = 3'd5,
    ERR_FLUSH_DROP = 3'd6,
    ERR_FLUSH_ACK  = 3'd7
  } err_e;

  localparam int ERR_NUM = 8;

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_BUSY  = 2'd1,
    FL_ACKED = 2'd2
  } flush_state_e;

  localparam int LAT_BINS = 8;

endpackage

// File: rtl/dcache_ts_fifo.sv
// Per-port timestamp FIFO. Depth must be a power of two and at least 2.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module dcache_ts_fifo #(
  parameter int Depth   = 4,
  parameter int TsWidth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [TsWidth-1:0]         data_i,
  output logic [TsWidth-1:0]         head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] occ_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int OccW = $clog2(Depth+1);

  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]    occ_q;
  logic [TsWidth-1:0] mem_q [Depth];
  logic               push_eff, pop_eff;

  assign empty_o  = (occ_q == '0);
  assign full_o   = (occ_q == OccW'(Depth));
  assign pop_eff  = pop_i & ~empty_o;
  assign push_eff = push_i & (~full_o | pop_eff);
  assign head_o   = mem_q[rd_ptr_q];
  assign occ_o    = occ_q;

  // Pointer and occupancy control; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Timestamp storage; contents are only meaningful while occupied.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dcache_port_tracker.sv
// N-port protocol tracker for dcache request ports and the flush handshake.
// Optional feature macro: DCACHE_TRACKER_LAT_HIST_EN adds lat_hist_o, a
// per-port log2 latency histogram (8 bins, saturating).
module dcache_port_tracker
  import dcache_tracker_pkg::*;
#(
  parameter int NrPorts        = 3,
  parameter int MaxOutstanding = 4,
  parameter int CntWidth       = 32,
  parameter int TsWidth        = 16,
  parameter int Timeout        = 256,
  parameter int ExclusiveGnt   = 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          clear_i,
  input  logic [NrPorts-1:0]                            req_i,
  input  logic [NrPorts-1:0]                            we_i,
  input  logic [NrPorts-1:0]                            gnt_i,
  input  logic [NrPorts-1:0]                            rvalid_i,
  input  logic                                          flush_i,
  input  logic                                          flush_ack_i,
  output logic [NrPorts*CntWidth-1:0]                   rd_cnt_o,
  output logic [NrPorts*CntWidth-1:0]                   wr_cnt_o,
  output logic [NrPorts*$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic [NrPorts*TsWidth-1:0]                    max_lat_o,
  output logic [CntWidth-1:0]                           flush_cyc_o,
  output logic [ERR_NUM-1:0]                            err_o,
`ifdef DCACHE_TRACKER_LAT_HIST_EN
  output logic [NrPorts*LAT_BINS*CntWidth-1:0]          lat_hist_o,
`endif
  output logic [((NrPorts > 1) ? $clog2(NrPorts) : 1)-1:0] err_port_o
);

  localparam int OccW  = $clog2(MaxOutstanding+1);
  localparam int PortW = (NrPorts > 1) ? $clog2(NrPorts) : 1;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef DCACHE_TRACKER_LAT_HIST_EN
  function automatic logic [2:0] lat_bin(input logic [TsWidth-1:0] lat);
    logic [2:0] b;
    b = 3'd0;
    for (int i = 1; i < TsWidth; i++) begin
      if (lat[i]) b = (i >= 7) ? 3'd7 : 3'(i);
    end
    return b;
  endfunction
`endif

  logic [TsWidth-1:0] ts_q;
  logic [NrPorts-1:0] rd_acc, wr_acc;
  logic [NrPorts-1:0] err_rvalid, err_ovf, err_spur, err_drop, err_tmo, port_err;
  logic [ERR_NUM-1:0] err_now, err_q;
  logic [PortW-1:0]   first_port, err_port_q;
  logic               err_port_vld_q;

  assign rd_acc = req_i & gnt_i & ~we_i;
  assign wr_acc = req_i & gnt_i & we_i;

  // Free-running timestamp, wraps at 2^TsWidth.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) ts_q <= '0;
    else                    ts_q <= ts_q + 1'b1;
  end

  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    logic [TsWidth-1:0]  head, lat_p0, max_lat_q, age;
    logic [OccW-1:0]     occ;
    logic                full, empty, pop_vld_p0, req_pend_q;
    logic [CntWidth-1:0] rd_cnt_q, wr_cnt_q;

    dcache_ts_fifo #(
      .Depth   (MaxOutstanding),
      .TsWidth (TsWidth)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push_i  (rd_acc[p]),
      .pop_i   (rvalid_i[p]),
      .data_i  (ts_q),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .occ_o   (occ)
    );

    assign age           = ts_q - head;
    assign err_rvalid[p] = rvalid_i[p] & empty;
    assign err_ovf[p]    = rd_acc[p] & full & ~(rvalid_i[p] & ~empty);
    assign err_spur[p]   = gnt_i[p] & ~req_i[p];
    assign err_drop[p]   = req_pend_q & ~req_i[p];
    assign err_tmo[p]    = ~empty & (age >= TsWidth'(Timeout));

    // Handshake counters, pop tracking and max latency (updated the cycle after the pop).
    always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
        rd_cnt_q   <= '0;
        wr_cnt_q   <= '0;
        max_lat_q  <= '0;
        pop_vld_p0 <= 1'b0;
        req_pend_q <= 1'b0;
      end else begin
        if (rd_acc[p]) rd_cnt_q <= sat_inc(rd_cnt_q);
        if (wr_acc[p]) wr_cnt_q <= sat_inc(wr_cnt_q);
        pop_vld_p0 <= rvalid_i[p] & ~empty;
        req_pend_q <= req_i[p] & ~gnt_i[p];
        if (pop_vld_p0 && (lat_p0 > max_lat_q)) max_lat_q <= lat_p0;
      end
    end

    // Stage 0: latency of the entry being popped, qualified by pop_vld_p0.
    always_ff @(posedge clk_i) begin
      lat_p0 <= age;
    end

`ifdef DCACHE_TRACKER_LAT_HIST_EN
    logic [LAT_BINS-1:0][CntWidth-1:0] hist_q;

    // Saturating latency histogram fed from the stage-0 latency.
    always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) hist_q <= '0;
      else if (pop_vld_p0) hist_q[lat_bin(lat_p0)] <= sat_inc(hist_q[lat_bin(lat_p0)]);
    end

    assign lat_hist_o[p*LAT_BINS*CntWidth +: LAT_BINS*CntWidth] = hist_q;
`endif

    assign rd_cnt_o[p*CntWidth +: CntWidth] = rd_cnt_q;
    assign wr_cnt_o[p*CntWidth +: CntWidth] = wr_cnt_q;
    assign outstanding_o[p*OccW +: OccW]    = occ;
    assign max_lat_o[p*TsWidth +: TsWidth]  = max_lat_q;
  end

  assign port_err = err_rvalid | err_ovf | err_spur | err_drop | err_tmo;

  // Lowest-index port among this cycle's port-related violations.
  always_comb begin
    first_port = '0;
    for (int p = NrPorts-1; p >= 0; p--) begin
      if (port_err[p]) first_port = PortW'(p);
    end
  end

  flush_state_e        fl_state_q;
  logic [CntWidth-1:0] fl_cnt_q, flush_cyc_q;
  logic                acked_hi_q;

  // Combined violation vector for this cycle, registered below as sticky bits.
  always_comb begin
    err_now                 = '0;
    err_now[ERR_RVALID]     = |err_rvalid;
    err_now[ERR_OVF]        = |err_ovf;
    err_now[ERR_SPUR_GNT]   = |err_spur;
    err_now[ERR_REQ_DROP]   = |err_drop;
    err_now[ERR_MULTI_GNT]  = (ExclusiveGnt != 0) && ((gnt_i & (gnt_i - 1'b1)) != '0);
    err_now[ERR_TIMEOUT]    = |err_tmo;
    err_now[ERR_FLUSH_DROP] = (fl_state_q == FL_BUSY) && !flush_ack_i && !flush_i;
    err_now[ERR_FLUSH_ACK]  = (fl_state_q == FL_IDLE) && flush_ack_i;
  end

  // Sticky error bits and first-offending-port latch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      err_q          <= '0;
      err_port_q     <= '0;
      err_port_vld_q <= 1'b0;
    end else begin
      err_q <= err_q | err_now;
      if (!err_port_vld_q && (|port_err)) begin
        err_port_q     <= first_port;
        err_port_vld_q <= 1'b1;
      end
    end
  end

  // Flush FSM: cycle count from request to ack; one trailing high cycle after ack is tolerated.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      fl_state_q  <= FL_IDLE;
      fl_cnt_q    <= '0;
      flush_cyc_q <= '0;
      acked_hi_q  <= 1'b0;
    end else begin
      case (fl_state_q)
        FL_IDLE: begin
          if (flush_i) begin
            fl_state_q <= FL_BUSY;
            fl_cnt_q   <= CntWidth'(1);
          end
        end
        FL_BUSY: begin
          fl_cnt_q <= sat_inc(fl_cnt_q);
          if (flush_ack_i) begin
            flush_cyc_q <= sat_inc(fl_cnt_q);
            fl_state_q  <= FL_ACKED;
            acked_hi_q  <= 1'b0;
          end else if (!flush_i) begin
            fl_state_q <= FL_IDLE;
          end
        end
        FL_ACKED: begin
          if (!flush_i) begin
            fl_state_q <= FL_IDLE;
          end else if (acked_hi_q) begin
            fl_state_q <= FL_BUSY;
            fl_cnt_q   <= CntWidth'(1);
          end else begin
            acked_hi_q <= 1'b1;
          end
        end
        default: fl_state_q <= FL_IDLE;
      endcase
    end
  end

  assign flush_cyc_o = flush_cyc_q;
  assign err_o       = err_q;
  assign err_port_o  = err_port_q;

endmodule

// File: tb/tb_dcache_port_tracker.sv
// Directed bench for dcache_port_tracker with hand-computed expectations.
// A second instance with ExclusiveGnt=0 shares all inputs.
module tb_dcache_port_tracker;
  import dcache_tracker_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, clear, flush, flush_ack;
  logic [2:0] req, we, gnt, rvalid;

  logic [95:0] rd_cnt, wr_cnt, rd_cnt2, wr_cnt2;
  logic [8:0]  outst, outst2;
  logic [47:0] max_lat, max_lat2;
  logic [31:0] flush_cyc, flush_cyc2;
  logic [7:0]  err, err2;
  logic [1:0]  err_port, err_port2;
`ifdef DCACHE_TRACKER_LAT_HIST_EN
  logic [767:0] hist, hist2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_port_tracker dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .req_i(req), .we_i(we),
    .gnt_i(gnt), .rvalid_i(rvalid), .flush_i(flush), .flush_ack_i(flush_ack),
    .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .outstanding_o(outst),
    .max_lat_o(max_lat), .flush_cyc_o(flush_cyc), .err_o(err),
`ifdef DCACHE_TRACKER_LAT_HIST_EN
    .lat_hist_o(hist),
`endif
    .err_port_o(err_port)
  );

  dcache_port_tracker #(.ExclusiveGnt(0)) dut_ng (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .req_i(req), .we_i(we),
    .gnt_i(gnt), .rvalid_i(rvalid), .flush_i(flush), .flush_ack_i(flush_ack),
    .rd_cnt_o(rd_cnt2), .wr_cnt_o(wr_cnt2), .outstanding_o(outst2),
    .max_lat_o(max_lat2), .flush_cyc_o(flush_cyc2), .err_o(err2),
`ifdef DCACHE_TRACKER_LAT_HIST_EN
    .lat_hist_o(hist2),
`endif
    .err_port_o(err_port2)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; we = '0; gnt = '0; rvalid = '0; flush = 1'b0; flush_ack = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic logic [127:0] bit_of(input err_e e);
    logic [127:0] v;
    v = '0;
    v[e] = 1'b1;
    return v;
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset_rd_cnt", rd_cnt, 0);
    check("reset_outst", outst, 0);
    check("reset_err", err, 0);
    check("reset_flush_cyc", flush_cyc, 0);

    // Read on port 0, rvalid three cycles later
    for (int i = 0; i < 8; i++) tick();
    req = 3'b001; gnt = 3'b001;
    tick();
    idle();
    check("t1_outst_after_gnt", outst[2:0], 1);
    check("t1_rd_cnt0", rd_cnt[31:0], 1);
    tick(); tick();
    rvalid = 3'b001;
    tick();
    idle();
    check("t1_outst_after_rvalid", outst[2:0], 0);
    tick();
    check("t1_max_lat0", max_lat[15:0], 3);
    check("t1_err", err, 0);

    // Five back-to-back reads on port 1 into a depth-4 FIFO
    req = 3'b010; gnt = 3'b010;
    for (int i = 0; i < 5; i++) tick();
    idle();
    tick();
    check("t2_outst1", outst[5:3], 4);
    check("t2_rd_cnt1", rd_cnt[63:32], 5);
    check("t2_err_ovf", err, bit_of(ERR_OVF));
    check("t2_err_port", err_port, 1);

    // Clear wins over a same-cycle grant
    req = 3'b001; gnt = 3'b001; clear = 1'b1;
    tick();
    idle();
    check("t3_clear_err", err, 0);
    check("t3_clear_rd_cnt", rd_cnt, 0);
    check("t3_clear_outst", outst, 0);
    check("t3_clear_max_lat", max_lat, 0);

    // rvalid on port 2 with nothing outstanding
    rvalid = 3'b100;
    tick();
    idle();
    tick();
    check("t3_err_rvalid", err, bit_of(ERR_RVALID));
    check("t3_err_port", err_port, 2);

    // rvalid in the same cycle as the first grant is illegal; push still happens
    do_clear();
    req = 3'b001; gnt = 3'b001; rvalid = 3'b001;
    tick();
    idle();
    tick();
    check("t3_lat0_err", err, bit_of(ERR_RVALID));
    check("t3_lat0_outst", outst[2:0], 1);

    // Two grants in one cycle
    do_clear();
    req = 3'b011; gnt = 3'b011;
    tick();
    idle();
    tick();
    check("t4_multi_gnt", err, bit_of(ERR_MULTI_GNT));
    check("t4_multi_gnt_off", err2, 0);
    check("t4_rd_cnt", rd_cnt[63:0], {32'd1, 32'd1});

    // Write handshake, spurious grant and dropped request
    do_clear();
    req = 3'b001; we = 3'b001; gnt = 3'b001;
    tick();
    idle();
    check("t4_wr_cnt0", wr_cnt[31:0], 1);
    check("t4_wr_outst", outst, 0);
    check("t4_wr_err", err, 0);
    gnt = 3'b100;
    tick();
    idle();
    tick();
    check("t4_spur_gnt", err, bit_of(ERR_SPUR_GNT));
    check("t4_spur_port", err_port, 2);
    do_clear();
    req = 3'b010;
    tick();
    idle();
    tick();
    check("t4_req_drop", err, bit_of(ERR_REQ_DROP));
    check("t4_req_drop_port", err_port, 1);

    // Flush of 7 cycles, then an ack with no flush pending
    do_clear();
    flush = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      flush_ack = (i == 7);
      tick();
    end
    idle();
    tick();
    check("t5_flush_cyc", flush_cyc, 7);
    check("t5_flush_err", err, 0);
    flush_ack = 1'b1;
    tick();
    idle();
    tick();
    check("t5_flush_ack_err", err, bit_of(ERR_FLUSH_ACK));
    check("t5_flush_cyc_hold", flush_cyc, 7);

    // Flush withdrawn before ack
    do_clear();
    flush = 1'b1;
    tick(); tick(); tick();
    idle();
    tick();
    check("t5_flush_drop", err, bit_of(ERR_FLUSH_DROP));
    check("t5_flush_drop_cyc", flush_cyc, 0);

    // Timeout boundary: age 255 clean, age 256 flagged
    do_clear();
    req = 3'b001; gnt = 3'b001;
    tick();
    idle();
    for (int i = 0; i < 255; i++) tick();
    check("t6_no_timeout_255", err, 0);
    tick();
    check("t6_timeout", err, bit_of(ERR_TIMEOUT));
    check("t6_timeout_port", err_port, 0);

    // Reset in the middle of a read burst and a flush
    req = 3'b010; gnt = 3'b010; flush = 1'b1;
    tick(); tick();
    check("t6_burst_rd_cnt1", rd_cnt[63:32], 2);
    rst_n = 1'b0;
    tick();
    check("t6_rst_rd_cnt", rd_cnt, 0);
    check("t6_rst_wr_cnt", wr_cnt, 0);
    check("t6_rst_outst", outst, 0);
    check("t6_rst_max_lat", max_lat, 0);
    check("t6_rst_flush_cyc", flush_cyc, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_err_port", err_port, 0);
    idle();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
